// File: rtl/mmio_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_initiator
// Description : Single-outstanding master for the native valid/ready memory bus.
//               Turns one command into one bus access and returns one response.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_valid_o,
    output logic        mem_instr_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Count value on the last permitted unacknowledged cycle
    localparam logic [TIMEOUT_W-1:0] c_COUNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_mem_valid;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_wstrb;
    logic                  r_busy;
    logic [TIMEOUT_W-1:0]  r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
            r_busy      <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mem_addr  <= {cmd_addr_i[31:2], 2'b00};
                        r_mem_wdata <= cmd_wdata_i;
                        r_mem_wstrb <= cmd_write_i ? cmd_wstrb_i : 4'h0;
                        r_count     <= '0;
                        // A write that enables no bytes is rejected without a bus cycle
                        if (cmd_write_i && (cmd_wstrb_i == 4'h0)) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else begin
                            r_state     <= S_BUS;
                            r_mem_valid <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ready_i) begin
                        r_state     <= S_RESP;
                        r_mem_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= (r_mem_wstrb == 4'h0) ? mem_rdata_i : 32'h0;
                    end else if (r_count == c_COUNT_LAST) begin
                        r_state     <= S_RESP;
                        r_mem_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mem_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign mem_valid_o = r_mem_valid;
    assign mem_instr_o = 1'b0;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wstrb_o = r_mem_wstrb;
    assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bus_initiator
// Description : Self-checking bench for mmio_bus_initiator with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_initiator;

    localparam int c_TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = 32'h0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic [3:0]  cmd_wstrb_i = 4'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_valid_o;
    logic        mem_instr_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_bus_initiator #(
        .TIMEOUT_CYCLES (c_TO),
        .TIMEOUT_W      (8)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_wstrb_i (cmd_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .mem_valid_o (mem_valid_o),
        .mem_instr_o (mem_instr_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_mem_valid"}, 32'(mem_valid_o), 32'd0);
        check({tag, "_busy"},      32'(busy_o),      32'd0);
    endtask

    // One command: responder acks after 'waits' unacknowledged cycles,
    // host holds off the response for 'hold' cycles while offering another command.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int waits, input logic [31:0] rd,
                          input int hold);
        logic        zero_strobe;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          nvalid;

        zero_strobe = wr && (st == 4'h0);
        if (zero_strobe) begin
            exp_n = 0; exp_err = 1'b1; exp_rdata = 32'h0;
        end else if (waits < c_TO) begin
            exp_n = waits + 1; exp_err = 1'b0; exp_rdata = wr ? 32'h0 : rd;
        end else begin
            exp_n = c_TO; exp_err = 1'b1; exp_rdata = 32'h0;
        end

        @(negedge clk);
        check("cmd_ready_before", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
        cmd_wdata_i = wd;   cmd_wstrb_i = st;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom); cmd_addr_i = $urandom;
        cmd_wdata_i = $urandom;     cmd_wstrb_i = 4'($urandom);

        nvalid = 0;
        @(negedge clk);
        while (mem_valid_o && nvalid < 300) begin
            check("mem_addr",  mem_addr_o,            {addr[31:2], 2'b00});
            check("mem_wstrb", 32'(mem_wstrb_o),      32'(wr ? st : 4'h0));
            check("mem_wdata", mem_wdata_o,           wd);
            check("mem_instr", 32'(mem_instr_o),      32'd0);
            check("rsp_early", 32'(rsp_valid_o),      32'd0);
            mem_ready_i = (nvalid == waits);
            mem_rdata_i = (nvalid == waits) ? rd : $urandom;
            @(posedge clk);
            #1;
            mem_ready_i = 1'b0;
            nvalid++;
            @(negedge clk);
        end
        check("valid_cycles", 32'(nvalid), 32'(exp_n));
        check("rsp_valid",    32'(rsp_valid_o), 32'd1);
        check("rsp_err",      32'(rsp_err_o),   32'(exp_err));
        check("rsp_rdata",    rsp_rdata_o,      exp_rdata);
        check("busy_resp",    32'(busy_o),      32'd1);
        check("cmd_ready_resp", 32'(cmd_ready_o), 32'd0);

        for (int h = 0; h < hold; h++) begin
            cmd_valid_i = 1'b1;
            mem_ready_i = 1'($urandom);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_err",   32'(rsp_err_o),   32'(exp_err));
            check("hold_rdata", rsp_rdata_o,      exp_rdata);
            check("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("hold_mem_valid", 32'(mem_valid_o), 32'd0);
        end
        cmd_valid_i = 1'b0;
        mem_ready_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        check_idle("after_rsp");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_addr",  mem_addr_o,          32'h0);
        check("reset_wdata", mem_wdata_o,         32'h0);
        check("reset_wstrb", 32'(mem_wstrb_o),    32'h0);
        check("reset_rdata", rsp_rdata_o,         32'h0);
        check("reset_err",   32'(rsp_err_o),      32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Zero-wait write, wait-state read, timeout, ack on the last legal cycle
        do_txn(1'b1, 32'h1000_0004, 32'h7,         4'hF, 0,   32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h1000_000E, 32'h0,         4'h5, 3,   32'h2,         0);
        do_txn(1'b0, 32'h1000_0020, 32'h0,         4'h0, 100, 32'h1234_5678, 0);
        do_txn(1'b1, 32'h1000_0030, 32'hA5A5_0001, 4'h3, c_TO - 1, 32'hFFFF_FFFF, 1);
        // Zero-strobe write, then response backpressure
        do_txn(1'b1, 32'h1000_0008, 32'h55,        4'h0, 0,   32'h9,         0);
        do_txn(1'b0, 32'h0000_0101, 32'h0,         4'h0, 1,   32'hCAFE_F00D, 5);

        // Reset while the bus request is outstanding
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h1000_0040;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("rst_bus_valid_pre", 32'(mem_valid_o), 32'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check_idle("rst_bus");
        check("rst_bus_addr", mem_addr_o, 32'h0);
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h1;
        repeat (3) begin
            @(negedge clk);
            check("rst_bus_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        mem_ready_i = 1'b0;

        // Randomized traffic against the transaction-level model
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
